// File: rtl/dram_cmd_timing_checker_pkg.sv
// Shared types, timing constants and helpers for the DRAM command timing checker.
// Timing values come from the CYCLE_* macros; defaults apply only when nothing else defines them.
`ifndef CYCLE_TRCD
`define CYCLE_TRCD 4
`endif
`ifndef CYCLE_TRP
`define CYCLE_TRP 4
`endif
`ifndef CYCLE_TRTP
`define CYCLE_TRTP 2
`endif
`ifndef CYCLE_TOTAL_WL
`define CYCLE_TOTAL_WL 3
`endif
`ifndef CYCLE_TWR
`define CYCLE_TWR 5
`endif
`ifndef BA_BITS
`define BA_BITS 3
`endif

package usertype;

    localparam int BA_BITS   = `BA_BITS;
    localparam int NUM_BANKS = 8;

    typedef enum logic [2:0] {
        C_NOP = 3'd0,
        C_ACT = 3'd1,
        C_RD  = 3'd2,
        C_WR  = 3'd3,
        C_PRE = 3'd4,
        C_REF = 3'd5
    } cmd_t;

    typedef enum logic [2:0] {
        V_NONE      = 3'd0,
        V_TRCD      = 3'd1,
        V_TRP       = 3'd2,
        V_TRTP      = 3'd3,
        V_TWR       = 3'd4,
        V_ACT_OPEN  = 3'd5,
        V_RW_CLOSED = 3'd6,
        V_REF_BUSY  = 3'd7
    } viol_t;

    typedef enum logic [1:0] {
        B_IDLE        = 2'd0,
        B_ACTIVE      = 2'd1,
        B_AUTOPRE     = 2'd2,
        B_PRECHARGING = 2'd3
    } bank_state_t;

    // Timer reload values: an issue loads N-1 so the dependent command lands N cycles later.
    localparam logic [4:0] T_RCD   = 5'(`CYCLE_TRCD - 1);
    localparam logic [4:0] T_RP    = 5'(`CYCLE_TRP - 1);
    localparam logic [4:0] T_RTP   = 5'(`CYCLE_TRTP - 1);
    localparam logic [4:0] T_WRREC = 5'(`CYCLE_TOTAL_WL + 2 + `CYCLE_TWR - 1);

    function automatic logic [4:0] tmax(input logic [4:0] a, input logic [4:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_cmd_timing_checker_if.sv
// Command bus and violation report bundle of the DRAM command timing checker.
interface dram_cmd_timing_checker_if;
    import usertype::*;

    logic                 cmd_valid;
    cmd_t                 cmd;
    logic [BA_BITS-1:0]   cmd_bank;
    logic                 cmd_auto_pre;
    logic                 viol_valid;
    viol_t                viol_code;
    logic [BA_BITS-1:0]   viol_bank;
    logic [7:0]           viol_count;
    logic [NUM_BANKS-1:0] bank_open;
    logic                 all_idle;

    modport master (
        output cmd_valid, cmd, cmd_bank, cmd_auto_pre,
        input  viol_valid, viol_code, viol_bank, viol_count, bank_open, all_idle
    );

    modport slave (
        input  cmd_valid, cmd, cmd_bank, cmd_auto_pre,
        output viol_valid, viol_code, viol_bank, viol_count, bank_open, all_idle
    );
endinterface

// File: rtl/dram_cmd_timing_checker_bank.sv
// Per-bank state, down-timer and last-write tracking; flags illegal commands to this bank.
module dram_bank_tracker
    import usertype::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  issue,
    input  cmd_t  cmd,
    input  logic  auto_pre,
    output logic  viol,
    output viol_t code,
    output logic  open_nxt,
    output logic  idle_nxt,
    output logic  busy
);

    bank_state_t state, state_nxt;
    logic [4:0]  timer, timer_nxt, timer_dec;
    logic        last_wr, last_wr_nxt;

    always_comb begin
        timer_dec   = (timer == '0) ? '0 : timer - 5'd1;
        viol        = 1'b0;
        code        = V_NONE;
        state_nxt   = state;
        timer_nxt   = timer_dec;
        last_wr_nxt = last_wr;

        // Precharge completes as the timer reaches zero so ACT is legal exactly tRP after PRE.
        case (state)
            B_AUTOPRE:     if (timer == '0) begin
                               state_nxt = B_PRECHARGING;
                               timer_nxt = T_RP;
                           end
            B_PRECHARGING: if (timer_dec == '0) state_nxt = B_IDLE;
            default: ;
        endcase

        if (issue) begin
            case (cmd)
                C_ACT: begin
                    if (state == B_ACTIVE) begin
                        viol = 1'b1;
                        code = V_ACT_OPEN;
                    end else if (state == B_IDLE && timer == '0) begin
                        state_nxt = B_ACTIVE;
                        timer_nxt = T_RCD;
                    end else begin
                        viol = 1'b1;
                        code = V_TRP;
                    end
                end
                C_RD, C_WR: begin
                    if (state != B_ACTIVE) begin
                        viol = 1'b1;
                        code = V_RW_CLOSED;
                    end else if (timer != '0) begin
                        viol = 1'b1;
                        code = V_TRCD;
                    end else begin
                        timer_nxt   = tmax(timer, (cmd == C_WR) ? T_WRREC : T_RTP);
                        last_wr_nxt = (cmd == C_WR);
                        if (auto_pre) state_nxt = B_AUTOPRE;
                    end
                end
                C_PRE: begin
                    case (state)
                        B_ACTIVE: begin
                            if (timer == '0) begin
                                state_nxt = B_PRECHARGING;
                                timer_nxt = T_RP;
                            end else begin
                                viol = 1'b1;
                                code = last_wr ? V_TWR : V_TRTP;
                            end
                        end
                        B_AUTOPRE: begin
                            viol = 1'b1;
                            code = V_RW_CLOSED;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end

        open_nxt = (state_nxt == B_ACTIVE) || (state_nxt == B_AUTOPRE);
        idle_nxt = (state_nxt == B_IDLE) && (timer_nxt == '0);
        busy     = !((state == B_IDLE) && (timer == '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= B_IDLE;
            timer   <= '0;
            last_wr <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            last_wr <= last_wr_nxt;
        end
    end

endmodule

// File: rtl/dram_cmd_timing_checker.sv
// DRAM command timing checker: eight bank trackers plus the REF check and violation reporting.
module dram_cmd_timing_checker
    import usertype::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    dram_cmd_timing_checker_if.slave  bus
);

    logic [NUM_BANKS-1:0] bank_viol, bank_open_nxt, bank_idle_nxt, bank_busy;
    viol_t                bank_code [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        dram_bank_tracker u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .issue    (bus.cmd_valid && (bus.cmd_bank == BA_BITS'(b))),
            .cmd      (bus.cmd),
            .auto_pre (bus.cmd_auto_pre),
            .viol     (bank_viol[b]),
            .code     (bank_code[b]),
            .open_nxt (bank_open_nxt[b]),
            .idle_nxt (bank_idle_nxt[b]),
            .busy     (bank_busy[b])
        );
    end

    logic               viol_valid_q, all_idle_q;
    viol_t              viol_code_q;
    logic [BA_BITS-1:0] viol_bank_q;
    logic [7:0]         viol_count_q;
    logic [NUM_BANKS-1:0] bank_open_q;

    logic               v_any;
    viol_t              v_code;
    logic [BA_BITS-1:0] v_bank;
    logic               found;

    always_comb begin
        v_any  = bank_viol[bus.cmd_bank];
        v_code = bank_code[bus.cmd_bank];
        v_bank = bus.cmd_bank;
        found  = 1'b0;
        if (bus.cmd_valid && bus.cmd == C_REF && !all_idle_q) begin
            v_any  = 1'b1;
            v_code = V_REF_BUSY;
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                if (bank_busy[i] && !found) begin
                    found  = 1'b1;
                    v_bank = BA_BITS'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            viol_valid_q <= 1'b0;
            viol_code_q  <= V_NONE;
            viol_bank_q  <= '0;
            viol_count_q <= '0;
            bank_open_q  <= '0;
            all_idle_q   <= 1'b1;
        end else begin
            viol_valid_q <= v_any;
            if (v_any) begin
                viol_code_q <= v_code;
                viol_bank_q <= v_bank;
                if (viol_count_q != '1) viol_count_q <= viol_count_q + 8'd1;
            end
            bank_open_q <= bank_open_nxt;
            all_idle_q  <= &bank_idle_nxt;
        end
    end

    assign bus.viol_valid = viol_valid_q;
    assign bus.viol_code  = viol_code_q;
    assign bus.viol_bank  = viol_bank_q;
    assign bus.viol_count = viol_count_q;
    assign bus.bank_open  = bank_open_q;
    assign bus.all_idle   = all_idle_q;

endmodule

// File: tb/tb_dram_cmd_timing_checker.sv
// Directed self-checking bench for dram_cmd_timing_checker (tRCD=4, tRP=4, tRTP=2, write recovery 10).
module tb_dram_cmd_timing_checker;
    import usertype::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    dram_cmd_timing_checker_if bus ();

    dram_cmd_timing_checker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one command for the next edge, then stand just after that edge.
    task automatic issue(input cmd_t c, input int b, input logic ap);
        bus.cmd_valid    = 1'b1;
        bus.cmd          = c;
        bus.cmd_bank     = 3'(b);
        bus.cmd_auto_pre = ap;
        @(posedge clk);
        #1;
        bus.cmd_valid    = 1'b0;
        bus.cmd          = C_NOP;
        bus.cmd_bank     = '0;
        bus.cmd_auto_pre = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd          = C_NOP;
        bus.cmd_bank     = '0;
        bus.cmd_auto_pre = 1'b0;
        idle(2);
        chk("rst_viol_valid", 32'(bus.viol_valid), 0);
        chk("rst_viol_code",  32'(bus.viol_code),  0);
        chk("rst_viol_bank",  32'(bus.viol_bank),  0);
        chk("rst_viol_count", 32'(bus.viol_count), 0);
        chk("rst_bank_open",  32'(bus.bank_open),  0);
        chk("rst_all_idle",   32'(bus.all_idle),   1);
        rst_n = 1'b1;
        idle(1);

        // tRCD: RD 3 cycles after ACT is early, 4 cycles after is legal
        issue(C_ACT, 0, 1'b0);
        chk("act_b0_open", 32'(bus.bank_open), 32'h01);
        chk("act_b0_idle", 32'(bus.all_idle), 0);
        idle(2);
        issue(C_RD, 0, 1'b0);
        chk("trcd_valid", 32'(bus.viol_valid), 1);
        chk("trcd_code",  32'(bus.viol_code),  1);
        chk("trcd_bank",  32'(bus.viol_bank),  0);
        chk("trcd_count", 32'(bus.viol_count), 1);
        issue(C_RD, 0, 1'b0);
        chk("rd_ok_valid", 32'(bus.viol_valid), 0);
        chk("rd_ok_code_hold", 32'(bus.viol_code), 1);
        idle(3);
        issue(C_PRE, 0, 1'b0);
        chk("pre_b0_valid", 32'(bus.viol_valid), 0);
        idle(6);

        // write recovery then tRP on bank 1
        issue(C_ACT, 1, 1'b0);
        idle(3);
        issue(C_WR, 1, 1'b0);
        chk("wr_ok_valid", 32'(bus.viol_valid), 0);
        idle(8);
        issue(C_PRE, 1, 1'b0);
        chk("twr_valid", 32'(bus.viol_valid), 1);
        chk("twr_code",  32'(bus.viol_code),  4);
        chk("twr_bank",  32'(bus.viol_bank),  1);
        issue(C_PRE, 1, 1'b0);
        chk("pre_b1_valid", 32'(bus.viol_valid), 0);
        chk("pre_b1_closed", 32'(bus.bank_open), 0);
        idle(2);
        issue(C_ACT, 1, 1'b0);
        chk("trp_valid", 32'(bus.viol_valid), 1);
        chk("trp_code",  32'(bus.viol_code),  2);
        issue(C_ACT, 1, 1'b0);
        chk("act_b1_valid", 32'(bus.viol_valid), 0);
        chk("act_b1_open",  32'(bus.bank_open), 32'h02);
        idle(3);
        issue(C_PRE, 1, 1'b0);
        idle(5);

        // auto-precharge on bank 2
        issue(C_ACT, 2, 1'b0);
        chk("ap_open_t1", 32'(bus.bank_open[2]), 1);
        idle(3);
        issue(C_RD, 2, 1'b1);
        chk("ap_rd_valid", 32'(bus.viol_valid), 0);
        chk("ap_open_t5", 32'(bus.bank_open[2]), 1);
        idle(4);
        issue(C_ACT, 2, 1'b0);
        chk("ap_trp_valid", 32'(bus.viol_valid), 1);
        chk("ap_trp_code",  32'(bus.viol_code),  2);
        chk("ap_trp_bank",  32'(bus.viol_bank),  2);
        chk("ap_open_t10",  32'(bus.bank_open[2]), 0);
        issue(C_ACT, 2, 1'b0);
        chk("ap_act_valid", 32'(bus.viol_valid), 0);
        idle(3);
        issue(C_PRE, 2, 1'b0);
        idle(5);

        // access to a closed bank
        issue(C_RD, 3, 1'b0);
        chk("rwc_valid", 32'(bus.viol_valid), 1);
        chk("rwc_code",  32'(bus.viol_code),  6);
        chk("rwc_bank",  32'(bus.viol_bank),  3);
        idle(1);
        chk("pulse_one_cycle", 32'(bus.viol_valid), 0);

        // REF while bank 5 open, then after it has precharged
        issue(C_ACT, 5, 1'b0);
        idle(3);
        issue(C_REF, 0, 1'b0);
        chk("refb_valid", 32'(bus.viol_valid), 1);
        chk("refb_code",  32'(bus.viol_code),  7);
        chk("refb_bank",  32'(bus.viol_bank),  5);
        chk("refb_state_kept", 32'(bus.bank_open), 32'h20);
        issue(C_PRE, 5, 1'b0);
        idle(4);
        chk("all_idle_after_pre", 32'(bus.all_idle), 1);
        issue(C_REF, 0, 1'b0);
        chk("ref_ok_valid", 32'(bus.viol_valid), 0);
        chk("ref_ok_idle",  32'(bus.all_idle), 1);
        chk("count_before_sat", 32'(bus.viol_count), 6);

        // saturation of the violation counter
        issue(C_ACT, 6, 1'b0);
        for (int i = 0; i < 260; i++) issue(C_ACT, 6, 1'b0);
        chk("sat_valid", 32'(bus.viol_valid), 1);
        chk("sat_code",  32'(bus.viol_code),  5);
        chk("sat_bank",  32'(bus.viol_bank),  6);
        chk("sat_count", 32'(bus.viol_count), 255);

        // reset mid-sequence, then first command checked against reset state
        rst_n = 1'b0;
        issue(C_ACT, 6, 1'b0);
        chk("mrst_viol_valid", 32'(bus.viol_valid), 0);
        chk("mrst_viol_code",  32'(bus.viol_code),  0);
        chk("mrst_viol_bank",  32'(bus.viol_bank),  0);
        chk("mrst_viol_count", 32'(bus.viol_count), 0);
        chk("mrst_bank_open",  32'(bus.bank_open),  0);
        chk("mrst_all_idle",   32'(bus.all_idle),   1);
        rst_n = 1'b1;
        issue(C_ACT, 6, 1'b0);
        chk("post_rst_valid", 32'(bus.viol_valid), 0);
        chk("post_rst_open",  32'(bus.bank_open), 32'h40);
        chk("post_rst_count", 32'(bus.viol_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
